// File: rtl/io_pkg.sv
// Shared definitions for the IO peripheral AXI4-Lite register block.
package io_pkg;

    // Register byte offsets; addr[3:2] selects the register
    localparam logic [3:0] IO_DATA_OUT    = 4'h0;
    localparam logic [3:0] IO_DIR         = 4'h4;
    localparam logic [3:0] IO_DATA_IN     = 4'h8;
    localparam logic [3:0] IO_EDGE_STATUS = 4'hC;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

    // Expand byte strobes into a per-bit write mask
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchronizer for asynchronous pad inputs with a rising-edge pulse.
module io_sync_edge #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] dly_q;

    // Synchronizer chain plus one extra delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/io_axil_regs.sv
// AXI4-Lite responder holding the GPIO output/direction registers, synchronized
// GPIO inputs and a W1C rising-edge status register with a level interrupt.
module io_axil_regs
    import io_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_GPIO_WIDTH       = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_GPIO_WIDTH-1:0]         gpio_o,
    output logic [C_GPIO_WIDTH-1:0]         gpio_t,
    input  logic [C_GPIO_WIDTH-1:0]         gpio_i,
    output logic                            irq
);

    localparam int unsigned GW = C_GPIO_WIDTH;

    // Write path state
    logic        aw_full_q, aw_full_d;
    logic        w_full_q, w_full_d;
    logic        awready_q, wready_q;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, commit;

    // Register file
    logic [GW-1:0] data_out_q, data_out_d;
    logic [GW-1:0] dir_q, dir_d;
    logic [GW-1:0] edge_q, edge_d;
    logic [GW-1:0] gpio_t_q;
    logic          irq_q;
    logic [31:0]   wmask, data_out_new, dir_new, clr;

    // Read path state
    rd_state_e   rd_state_q, rd_state_d;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        ar_hs;

    logic [GW-1:0] gpio_sync, gpio_rise;

    // Protection bits and byte-offset address bits carry no meaning here
    logic unused_sig;
    assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    io_sync_edge #(
        .WIDTH(GW)
    ) u_sync_edge (
        .clk  (ACLK),
        .rst_n(ARESETN),
        .d    (gpio_i),
        .sync (gpio_sync),
        .rise (gpio_rise)
    );

    // Holding-register flags and commit/B-channel next state
    always_comb begin
        aw_hs     = S_AXI_AWVALID && awready_q;
        w_hs      = S_AXI_WVALID && wready_q;
        commit    = aw_full_q && w_full_q && (!bvalid_q || S_AXI_BREADY);
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        bvalid_d  = bvalid_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) aw_full_d = 1'b1;
            if (w_hs) w_full_d = 1'b1;
            if (S_AXI_BREADY) bvalid_d = 1'b0;
        end
    end

    // Write path registers; READY is the registered inverse of the holding flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            bvalid_q  <= bvalid_d;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Register update on commit; a new edge beats a simultaneous W1C clear
    always_comb begin
        wmask        = strb_to_mask(wstrb_q);
        data_out_new = (32'(data_out_q) & ~wmask) | (wdata_q & wmask);
        dir_new      = (32'(dir_q) & ~wmask) | (wdata_q & wmask);
        clr          = '0;
        data_out_d   = data_out_q;
        dir_d        = dir_q;
        if (commit) begin
            case ({aw_idx_q, 2'b00})
                IO_DATA_OUT:    data_out_d = data_out_new[GW-1:0];
                IO_DIR:         dir_d = dir_new[GW-1:0];
                IO_EDGE_STATUS: clr = wdata_q & wmask;
                default:        ;
            endcase
        end
        edge_d = (edge_q & ~clr[GW-1:0]) | gpio_rise;
    end

    // Register file and registered GPIO/interrupt outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            data_out_q <= '0;
            dir_q      <= '0;
            edge_q     <= '0;
            gpio_t_q   <= '1;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            edge_q     <= edge_d;
            gpio_t_q   <= ~dir_d;
            irq_q      <= |edge_q;
        end
    end

    // Read data selection from current register contents
    always_comb begin
        case ({S_AXI_ARADDR[3:2], 2'b00})
            IO_DATA_OUT:    rd_mux = 32'(data_out_q);
            IO_DIR:         rd_mux = 32'(dir_q);
            IO_DATA_IN:     rd_mux = 32'(gpio_sync);
            IO_EDGE_STATUS: rd_mux = 32'(edge_q);
            default:        rd_mux = '0;
        endcase
    end

    // Read FSM next state and captured read data
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        ar_hs      = S_AXI_ARVALID && arready_q;
        case (rd_state_q)
            IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RESP;
                    rdata_d    = rd_mux;
                end
            end
            RESP: begin
                if (rvalid_q && S_AXI_RREADY) rd_state_d = IDLE;
            end
            default: rd_state_d = IDLE;
        endcase
    end

    // Read FSM state register and registered AR/R handshake outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= (rd_state_d == IDLE);
            rvalid_q   <= (rd_state_d == RESP);
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign gpio_o        = data_out_q;
    assign gpio_t        = gpio_t_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_io_axil_regs.sv
// Scoreboard bench for io_axil_regs: expected read data and write responses are
// queued when requests are issued and compared when the responder produces them.
module tb_io_axil_regs;

    logic        clk;
    logic        arstn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] gpio_o, gpio_t, gpio_i;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    logic [1:0]  b_q[$];

    io_axil_regs dut (
        .ACLK         (clk),
        .ARESETN      (arstn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .gpio_o       (gpio_o),
        .gpio_t       (gpio_t),
        .gpio_i       (gpio_i),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitors: a handshake at the next edge is visible at this negedge
    always @(negedge clk) begin
        if (arstn && rvalid && rready) begin
            if (rd_q.size() == 0) begin
                check("r_unexpected", 32'(rd_q.size()), 1);
            end else begin
                check("rdata", rdata, rd_q.pop_front());
                check("rresp", 32'(rresp), 0);
            end
        end
        if (arstn && bvalid && bready) begin
            if (b_q.size() == 0) check("b_unexpected", 32'(b_q.size()), 1);
            else check("bresp", 32'(bresp), 32'(b_q.pop_front()));
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int  n;
        bit  aw_hs, w_hs, done;
        b_q.push_back(2'b00);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            n++;
        end
        check("wr_accept", 32'({awvalid, wvalid}), 0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = bvalid && bready;
            tick();
            n++;
        end
        check("b_seen", 32'(done), 1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int n;
        bit done;
        rd_q.push_back(exp);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        check("ar_accept", 32'(done), 1);
        n = 0; done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = rvalid && rready;
            tick();
            n++;
        end
        check("r_seen", 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arstn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        gpio_i = '0;

        // Reset values
        repeat (3) tick();
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_rdata", rdata, 0);
        check("rst_gpio_o", gpio_o, 0);
        check("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        arstn = 1'b1;
        tick();
        check("rel_awready", 32'(awready), 1);
        check("rel_wready", 32'(wready), 1);
        check("rel_arready", 32'(arready), 1);

        // Byte strobe on reset contents
        axi_write(4'h0, 32'hFFFF_FFFF, 4'b0010);
        check("strb_gpio_o", gpio_o, 32'h0000_FF00);
        axi_read(4'h0, 32'h0000_FF00);

        // Basic map: DATA_IN ignores writes, EDGE_STATUS W1C of zero stays zero
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'hC, 32'd3, 4'hF);
        axi_write(4'h8, 32'd4, 4'hF);
        axi_read(4'h0, 32'd1);
        axi_read(4'h4, 32'd2);
        axi_read(4'h8, 32'd0);
        axi_read(4'hC, 32'd0);
        check("map_gpio_t", gpio_t, 32'hFFFF_FFFD);

        // W well ahead of AW, B stalled; a second write queues behind it
        b_q.push_back(2'b00);
        b_q.push_back(2'b00);
        bready = 1'b0;
        wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        check("w_only_gpio_o", gpio_o, 32'd1);
        awaddr = 4'h0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        check("late_aw_bvalid", 32'(bvalid), 1);
        check("late_aw_gpio_o", gpio_o, 32'hA5A5_A5A5);
        awaddr = 4'h4; awvalid = 1'b1;
        wdata = 32'h0000_00FF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_bvalid", 32'(bvalid), 1);
            check("stall_awready", 32'(awready), 0);
            check("stall_wready", 32'(wready), 0);
            check("stall_gpio_t", gpio_t, 32'hFFFF_FFFD);
            check("stall_gpio_o", gpio_o, 32'hA5A5_A5A5);
        end
        bready = 1'b1;
        tick();
        check("unstall_gpio_t", gpio_t, 32'hFFFF_FF00);
        check("unstall_bvalid", 32'(bvalid), 1);
        tick();
        check("drain_bvalid", 32'(bvalid), 0);
        check("drain_awready", 32'(awready), 1);

        // Rising edge on gpio_i[3]
        gpio_i = 32'h0000_0008;
        tick();
        tick();
        tick();
        check("edge_irq_e3", 32'(irq), 0);
        tick();
        check("edge_irq_e4", 32'(irq), 1);
        axi_read(4'h8, 32'h0000_0008);
        axi_read(4'hC, 32'h0000_0008);
        gpio_i = '0;
        repeat (4) tick();
        axi_write(4'hC, 32'h0000_0008, 4'hF);
        check("w1c_irq", 32'(irq), 0);
        axi_read(4'hC, 32'd0);

        // Clear commit coinciding with a new edge: the set wins
        gpio_i = 32'h0000_0008;
        tick();
        b_q.push_back(2'b00);
        bready = 1'b1;
        awaddr = 4'hC; awvalid = 1'b1;
        wdata = 32'h0000_0008; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) tick();
        check("coincide_irq", 32'(irq), 1);
        axi_read(4'hC, 32'h0000_0008);
        gpio_i = '0;

        // Read stalled on RREADY; a second AR waits for the R handshake
        rd_q.push_back(32'hA5A5_A5A5);
        araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
        tick();
        rd_q.push_back(32'h0000_00FF);
        araddr = 4'h4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstall_rvalid", 32'(rvalid), 1);
            check("rstall_rdata", rdata, 32'hA5A5_A5A5);
            check("rstall_arready", 32'(arready), 0);
        end
        rready = 1'b1;
        begin
            int  n;
            bit  done;
            n = 0; done = 1'b0;
            while (!done && n < 50) begin
                @(negedge clk);
                done = arready;
                tick();
                n++;
            end
            arvalid = 1'b0;
            check("ar2_accept", 32'(done), 1);
            n = 0; done = 1'b0;
            while (!done && n < 50) begin
                @(negedge clk);
                done = rvalid && rready;
                tick();
                n++;
            end
            check("r2_seen", 32'(done), 1);
        end

        // Reset while BVALID is pending
        bready = 1'b0;
        awaddr = 4'h0; awvalid = 1'b1;
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("prerst_bvalid", 32'(bvalid), 1);
        check("prerst_gpio_o", gpio_o, 32'h1234_5678);
        #2;
        arstn = 1'b0;
        #1;
        check("arst_bvalid", 32'(bvalid), 0);
        check("arst_awready", 32'(awready), 0);
        check("arst_arready", 32'(arready), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_gpio_o", gpio_o, 0);
        check("arst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        tick();
        arstn = 1'b1;
        tick();
        bready = 1'b1;
        axi_read(4'h0, 32'd0);
        axi_read(4'h4, 32'd0);
        axi_read(4'hC, 32'd0);

        repeat (2) tick();
        check("rd_q_empty", 32'(rd_q.size()), 0);
        check("b_q_empty", 32'(b_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
